// File: rtl/gate_sweep_pkg.sv
// Shared constants and helpers for the gate sweep controller.
package gate_sweep_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   // Ceiling log2 for elaboration-time width calculations
   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/gate_sweep_ctrl_hold_timer.sv
// Down-counter that sets how long each vector is held on the gate inputs.
// load_i reloads HOLD_CYCLES-1; dec_i counts down; zero_o flags the last hold cycle.
module sweep_hold_timer
   import gate_sweep_pkg::*;
#(
   parameter int HOLD_CYCLES = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   // A hold of one cycle still needs a one-bit counter
   localparam int HW = (clog2(HOLD_CYCLES) > 0) ? clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] RELOAD = HW'(HOLD_CYCLES - 1);

   logic [HW-1:0] cnt_q;
   logic [HW-1:0] cnt_d;

   // Load has priority; decrement never wraps below zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = RELOAD;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-check sequencer for a small combinational gate: walks every input
// vector, captures the gate's truth table and scores it against a reference.
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int N_IN        = 2,
   parameter int HOLD_CYCLES = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [2**N_IN-1:0]   expected_i,
   output logic [N_IN-1:0]      gate_in_o,
   input  logic                 gate_out_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [2**N_IN-1:0]   tt_o,
   output logic [N_IN:0]        err_count_o
);

   localparam int              N_VEC    = 2**N_IN;
   localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [N_IN-1:0]  idx_q;
   logic [N_VEC-1:0] exp_q;
   logic [N_VEC-1:0] tt_q;
   logic [N_IN:0]    err_q;
   logic             pass_q;

   logic             hold_zero;
   logic             hold_load;
   logic             hold_dec;
   logic             accept;
   logic             sample;
   logic             mismatch;
   logic [N_IN:0]    err_inc;

   sweep_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (hold_load),
      .dec_i  (hold_dec),
      .zero_o (hold_zero)
   );

   assign mismatch = (gate_out_i != exp_q[idx_q]);
   assign err_inc  = err_q + {{N_IN{1'b0}}, mismatch};

   // Next-state and timer control; sampling happens on the last hold cycle of a vector
   always_comb begin
      state_d   = state_q;
      hold_load = 1'b0;
      hold_dec  = 1'b0;
      accept    = 1'b0;
      sample    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               accept    = 1'b1;
               hold_load = 1'b1;
               state_d   = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (hold_zero) begin
               sample = 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_FINISH;
               end else begin
                  hold_load = 1'b1;
               end
            end else begin
               hold_dec = 1'b1;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sweep state: reference latch, vector index, captured table and score.
   // pass is resolved on the final sample so it is already valid while done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         exp_q   <= '0;
         tt_q    <= '0;
         err_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            exp_q  <= expected_i;
            tt_q   <= '0;
            err_q  <= '0;
            pass_q <= 1'b0;
            idx_q  <= '0;
         end
         if (sample) begin
            tt_q[idx_q] <= gate_out_i;
            err_q       <= err_inc;
            if (idx_q == IDX_LAST) begin
               pass_q <= (err_inc == '0);
            end else begin
               idx_q <= idx_q + 1'b1;
            end
         end
      end
   end

   assign busy_o      = (state_q == ST_DRIVE);
   assign done_o      = (state_q == ST_FINISH);
   assign gate_in_o   = busy_o ? idx_q : '0;
   assign pass_o      = pass_q;
   assign tt_o        = tt_q;
   assign err_count_o = err_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: one instance with a 10-cycle hold,
// one with a 1-cycle hold, each wired to a selectable behavioural gate.
module tb_gate_sweep_ctrl;

   localparam int GATE_AND  = 0;
   localparam int GATE_XOR  = 1;
   localparam int GATE_OR   = 2;
   localparam int GATE_NAND = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance 1 (HOLD_CYCLES=10)
   logic       start1 = 1'b0;
   logic [3:0] exp1 = 4'b0000;
   logic [1:0] gin1;
   logic       gout1;
   logic       busy1, done1, pass1;
   logic [3:0] tt1;
   logic [2:0] err1;
   int         gsel1 = GATE_AND;

   // Instance 2 (HOLD_CYCLES=1)
   logic       start2 = 1'b0;
   logic [3:0] exp2 = 4'b0000;
   logic [1:0] gin2;
   logic       gout2;
   logic       busy2, done2, pass2;
   logic [3:0] tt2;
   logic [2:0] err2;
   int         gsel2 = GATE_NAND;

   function automatic logic gate_fn(input int sel, input logic [1:0] g);
      logic a, b;
      a = g[1];
      b = g[0];
      case (sel)
         GATE_AND: return a & b;
         GATE_XOR: return a ^ b;
         GATE_OR:  return a | b;
         default:  return ~(a & b);
      endcase
   endfunction

   assign gout1 = gate_fn(gsel1, gin1);
   assign gout2 = gate_fn(gsel2, gin2);

   gate_sweep_ctrl #(.N_IN(2), .HOLD_CYCLES(10)) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start1),
      .expected_i  (exp1),
      .gate_in_o   (gin1),
      .gate_out_i  (gout1),
      .busy_o      (busy1),
      .done_o      (done1),
      .pass_o      (pass1),
      .tt_o        (tt1),
      .err_count_o (err1)
   );

   gate_sweep_ctrl #(.N_IN(2), .HOLD_CYCLES(1)) dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start2),
      .expected_i  (exp2),
      .gate_in_o   (gin2),
      .gate_out_i  (gout2),
      .busy_o      (busy2),
      .done_o      (done2),
      .pass_o      (pass2),
      .tt_o        (tt2),
      .err_count_o (err2)
   );

   typedef struct {
      logic [3:0] tt;
      logic [2:0] err;
      logic       pass;
      int         done_cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor for instance 1: every done pulse must match the oldest queued result
   always @(negedge clk) begin : mon1
      exp_t e;
      if (done1 === 1'b1) begin
         if (q1.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut1_unexpected_done: got done at cycle %0d, required none", cyc);
         end else begin
            e = q1.pop_front();
            check("dut1_done_cycle", cyc, e.done_cyc);
            check("dut1_tt", tt1, e.tt);
            check("dut1_err_count", err1, e.err);
            check("dut1_pass", pass1, e.pass);
            $display("dut1 sweep: cycle=%0d tt=%b err_count=%0d pass=%0d", cyc, tt1, err1, pass1);
         end
      end
   end

   // Monitor for instance 2
   always @(negedge clk) begin : mon2
      exp_t e;
      if (done2 === 1'b1) begin
         if (q2.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut2_unexpected_done: got done at cycle %0d, required none", cyc);
         end else begin
            e = q2.pop_front();
            check("dut2_done_cycle", cyc, e.done_cyc);
            check("dut2_tt", tt2, e.tt);
            check("dut2_err_count", err2, e.err);
            check("dut2_pass", pass2, e.pass);
            $display("dut2 sweep: cycle=%0d tt=%b err_count=%0d pass=%0d", cyc, tt2, err2, pass2);
         end
      end
   end

   // Single-cycle start on instance 1; returns the cycle count of the accept edge
   task automatic launch1(input int sel, input logic [3:0] ex, input logic [3:0] ett,
                          input logic [2:0] eerr, input logic epass, output int acc);
      exp_t e;
      @(posedge clk);
      #1;
      gsel1  = sel;
      exp1   = ex;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      acc    = cyc;
      e.tt = ett; e.err = eerr; e.pass = epass; e.done_cyc = acc + 40;
      q1.push_back(e);
   endtask

   task automatic wait_drain(input int which);
      int t;
      t = 0;
      while (((which == 1) ? q1.size() : q2.size()) != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      if (((which == 1) ? q1.size() : q2.size()) != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL dut%0d_done_timeout: got no done within 200 cycles, required one", which);
         if (which == 1) q1.delete(); else q2.delete();
      end
   endtask

   initial begin : stim
      int   acc;
      exp_t e;

      #2;
      check("rst_dut1_busy", busy1, 0);
      check("rst_dut1_done", done1, 0);
      check("rst_dut1_gate_in", gin1, 0);
      check("rst_dut1_tt", tt1, 0);
      check("rst_dut1_err", err1, 0);
      check("rst_dut1_pass", pass1, 0);
      check("rst_dut2_busy", busy2, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 1: AND gate, all match
      launch1(GATE_AND, 4'b1000, 4'b1000, 3'd0, 1'b1, acc);
      wait_drain(1);

      // 2: XOR gate against AND reference
      launch1(GATE_XOR, 4'b1000, 4'b0110, 3'd3, 1'b0, acc);
      wait_drain(1);

      // 3: start pulses mid-sweep are ignored; gate_in follows 00,01,10,11
      launch1(GATE_AND, 4'b1000, 4'b1000, 3'd0, 1'b1, acc);
      for (int k = 1; k <= 41; k++) begin
         @(negedge clk);
         if (k == 1 || k == 10 || k == 11 || k == 20 || k == 21 ||
             k == 30 || k == 31 || k == 40)
            check($sformatf("sweep_gate_in_k%0d", k), gin1, (k - 1) / 10);
         if (k == 1)  check("sweep_busy_first", busy1, 1);
         if (k == 41) begin
            check("sweep_gate_in_finish", gin1, 0);
            check("sweep_busy_finish", busy1, 0);
         end
         start1 = (k == 5 || k == 20);
      end
      start1 = 1'b0;
      wait_drain(1);
      repeat (50) @(negedge clk);

      // 4: async reset at cycle 25 of an XOR sweep, then an OR sweep
      launch1(GATE_XOR, 4'b0000, 4'b0000, 3'd0, 1'b0, acc);
      repeat (25) @(negedge clk);
      check("pre_rst_gate_in", gin1, 2);
      check("pre_rst_tt", tt1, 4'b0010);
      check("pre_rst_err", err1, 1);
      #2;
      rst_n = 1'b0;
      q1.delete();
      #1;
      check("mid_rst_busy", busy1, 0);
      check("mid_rst_done", done1, 0);
      check("mid_rst_gate_in", gin1, 0);
      check("mid_rst_tt", tt1, 0);
      check("mid_rst_err", err1, 0);
      check("mid_rst_pass", pass1, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      launch1(GATE_OR, 4'b1110, 4'b1110, 3'd0, 1'b1, acc);
      wait_drain(1);

      // 5: one-cycle hold, NAND gate
      @(posedge clk);
      #1;
      gsel2  = GATE_NAND;
      exp2   = 4'b0111;
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      acc    = cyc;
      e.tt = 4'b0111; e.err = 3'd0; e.pass = 1'b1; e.done_cyc = acc + 4;
      q2.push_back(e);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("hold1_gate_in_k%0d", k), gin2, k - 1);
      end
      wait_drain(2);

      // 6: start held high; reference changed mid-sweep only affects the next sweep
      @(posedge clk);
      #1;
      gsel1  = GATE_AND;
      exp1   = 4'b1000;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      e.tt = 4'b1000; e.err = 3'd0; e.pass = 1'b1; e.done_cyc = acc + 40;
      q1.push_back(e);
      e.tt = 4'b1000; e.err = 3'd1; e.pass = 1'b0; e.done_cyc = acc + 82;
      q1.push_back(e);
      repeat (10) @(posedge clk);
      #1;
      exp1 = 4'b0000;
      while (cyc < acc + 42) @(posedge clk);
      #1;
      start1 = 1'b0;
      wait_drain(1);
      repeat (50) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
